shift_seq_ctrl: RTL and testbench

//   Multi-cycle shift sequencer: accepts one shift request (data, amount, type) through a valid/ready handshake.

---
 rtl/shift_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Multi-cycle shift sequencer. It accepts one shift request (operand,
//   amount, type) over a valid/ready handshake. It shifts the operand
//   iteratively, moving at most STEP bit positions per clock. It then
//   holds the result until the consumer takes it. This is the low-area
//   alternative to the combinational shifter in the execute stage.
//
//   Optional feature macro: SHIFT_SEQ_ROTATE_EN
//     defined   : type 01 is rotate right (ror)
//     undefined : type 01 is arithmetic right shift (sra); no rotate logic
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   req_valid  in   1      request present
//   req_ready  out  1      request can be accepted (IDLE only)
//   req_data   in   WIDTH  operand
//   req_amt    in   AW     shift amount, 0..WIDTH-1
//   req_type   in   2      00=sll, 10=srl, 11=sra, 01=sra/ror
//   rsp_valid  out  1      result present
//   rsp_ready  in   1      consumer takes the result
//   rsp_data   out  WIDTH  shifted result
//   busy       out  1      operation in progress or result pending

module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  localparam int unsigned AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AW-1:0]    req_amt,
  input  logic [1:0]       req_type,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ROR
  } op_t;

  // STEP may equal WIDTH, so the step amount needs one bit more than cnt.
  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  state_t           state;
  op_t              op;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] work;

  logic [AW:0]      cnt_ext;
  logic [AW:0]      s;
  logic [WIDTH-1:0] next_work;
  logic             last_step;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic [2*WIDTH-1:0] rot_dbl;
`endif

  function automatic op_t decode_type(input logic [1:0] t);
    op_t r;
    case (t)
      2'b00:   r = OP_SLL;
      2'b10:   r = OP_SRL;
      2'b11:   r = OP_SRA;
`ifdef SHIFT_SEQ_ROTATE_EN
      default: r = OP_ROR;
`else
      default: r = OP_SRA;
`endif
    endcase
    return r;
  endfunction

  // One step of the iteration: s = min(STEP, cnt). Because s never exceeds
  // cnt, cnt cannot underflow. A sign fill repeated on every step equals a
  // single sign fill, because sra keeps the operand's top bit in place.
  always_comb begin
    cnt_ext   = {1'b0, cnt};
    s         = (cnt_ext > STEP_W) ? STEP_W : cnt_ext;
    last_step = (cnt_ext == s);
    next_work = work;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_dbl   = {work, work} >> s;
`endif
    case (op)
      OP_SLL:  next_work = work << s;
      OP_SRL:  next_work = work >> s;
      OP_SRA:  next_work = $unsigned($signed(work) >>> s);
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:  next_work = rot_dbl[WIDTH-1:0];
`endif
      default: next_work = work;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op        <= OP_SLL;
      cnt       <= '0;
      work      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // req_ready is high exactly while in IDLE.
          if (req_valid) begin
            work      <= req_data;
            op        <= decode_type(req_type);
            cnt       <= req_amt;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_amt == '0) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_data  <= req_data;
            end else begin
              state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          work <= next_work;
          cnt  <= cnt - s[AW-1:0];
          if (last_step) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= next_work;
          end
        end

        S_DONE: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  localparam int unsigned W    = 32;
  localparam int unsigned STEP = 4;
  localparam int unsigned AW   = $clog2(W);

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_data;
  logic [AW-1:0] req_amt;
  logic [1:0]    req_type;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          busy;

  int checks;
  int errors;

  shift_seq_ctrl #(.WIDTH(W), .STEP(STEP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_type  (req_type),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: single-cycle shift defined from the type encoding.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int unsigned a,
                                              input logic [1:0] t);
    logic signed [W-1:0] sd;
    sd = d;
    case (t)
      2'b00: return d << a;
      2'b10: return d >> a;
      2'b11: return sd >>> a;
      default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        if (a == 0) return d;
        return (d >> a) | (d << (W - a));
`else
        return sd >>> a;
`endif
      end
    endcase
  endfunction

  // One full transaction, starting #1 after an edge with the DUT idle.
  task automatic run_req(input string tag, input logic [W-1:0] d, input logic [AW-1:0] a,
                         input logic [1:0] t, input int hold);
    logic [W-1:0] exp;
    int unsigned  exp_lat;
    int unsigned  n;
    logic [W-1:0] held;
    exp     = ref_shift(d, a, t);
    exp_lat = (int'(a) + STEP - 1) / STEP;
    check({tag, ".ready"}, W'(req_ready), W'(1));
    req_valid = 1'b1;
    req_data  = d;
    req_amt   = a;
    req_type  = t;
    tick();
    check({tag, ".busy"}, W'(busy), W'(1));
    check({tag, ".rdy_lo"}, W'(req_ready), W'(0));
    n = 0;
    while (!rsp_valid && n < 64) begin
      // Garbage on the request port must be ignored while busy.
      req_valid = 1'($urandom);
      req_data  = $urandom;
      req_amt   = AW'($urandom);
      req_type  = 2'($urandom);
      tick();
      n++;
    end
    check({tag, ".lat"}, W'(n), W'(exp_lat));
    check({tag, ".data"}, rsp_data, exp);
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_data  = $urandom;
      tick();
      check({tag, ".hold_v"}, W'(rsp_valid), W'(1));
      check({tag, ".hold_d"}, rsp_data, held);
      check({tag, ".hold_r"}, W'(req_ready), W'(0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, ".post_v"}, W'(rsp_valid), W'(0));
    check({tag, ".post_r"}, W'(req_ready), W'(1));
    check({tag, ".post_b"}, W'(busy), W'(0));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    req_amt   = '0;
    req_type  = 2'b00;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst.ready", W'(req_ready), W'(1));
    check("rst.valid", W'(rsp_valid), W'(0));
    check("rst.busy",  W'(busy),      W'(0));
    check("rst.data",  rsp_data,      '0);

    run_req("sll9",   32'h0000_0001, 5'd9,  2'b00, 0);
    run_req("sra31",  32'h8000_0000, 5'd31, 2'b11, 0);
    run_req("srl31",  32'h8000_0000, 5'd31, 2'b10, 0);
    run_req("amt0a",  32'hDEAD_BEEF, 5'd0,  2'b00, 0);
    run_req("amt0b",  32'hDEAD_BEEF, 5'd0,  2'b11, 1);
    run_req("hold5",  32'h1234_5678, 5'd7,  2'b10, 5);
    run_req("type01", 32'h0000_00F1, 5'd4,  2'b01, 0);
    run_req("t01neg", 32'h8000_00F1, 5'd13, 2'b01, 2);

    // Abort a long shift two cycles in; outputs must clear immediately.
    req_valid = 1'b1;
    req_data  = 32'h8000_0000;
    req_amt   = 5'd31;
    req_type  = 2'b11;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort.ready", W'(req_ready), W'(1));
    check("abort.valid", W'(rsp_valid), W'(0));
    check("abort.busy",  W'(busy),      W'(0));
    check("abort.data",  rsp_data,      '0);
    tick();
    reset = 1'b0;
    tick();
    run_req("after_rst", 32'hF0F0_1234, 5'd17, 2'b00, 0);

    for (int i = 0; i < 200; i++) begin
      run_req("rand", $urandom, AW'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
